// File: rtl/controlador_ataque_pkg.sv
// Shared encodings and board dimensions for the attack controller.
package controlador_ataque_pkg;

  localparam int NUM_COLUNAS = 5;
  localparam int NUM_LINHAS  = 7;

  typedef enum logic [1:0] {
    OCIOSO,
    AVALIA,
    EXIBE,
    FIM
  } estado_t;

  typedef enum logic [1:0] {
    INVALIDO,
    REPETIDO,
    ACERTO,
    ERRO
  } resultado_t;

endpackage

// File: rtl/controlador_ataque_contador_tempo.sv
// LED hold timer: down-counter loaded with TEMPO_LED, done on its final cycle.
module contador_tempo #(
  parameter int TEMPO_LED = 381
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(TEMPO_LED + 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock) begin
    if (reset) begin
      contagem <= '0;
    end else if (load) begin
      contagem <= W'(TEMPO_LED);
    end else if (contagem != '0) begin
      contagem <= contagem - W'(1);
    end
  end

  assign done = (contagem <= W'(1));

endmodule

// File: rtl/controlador_ataque.sv
// Battleship attack controller: evaluates shots, keeps marks/hits/lives, drives LEDs.
// state  | meaning
// OCIOSO | waiting for a confirmed shot
// AVALIA | classify latched cell, update marks/lives
// EXIBE  | hold result LED for TEMPO_LED cycles
// FIM    | game over (defeat or victory) until reset
module controlador_ataque
  import controlador_ataque_pkg::*;
#(
  parameter int VIDA_INICIAL = 5,
  parameter int TEMPO_LED    = 381
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       confirmar,
  input  logic [2:0] coord_coluna,
  input  logic [2:0] coord_linha,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic [6:0] matriz0,
  output logic [6:0] matriz1,
  output logic [6:0] matriz2,
  output logic [6:0] matriz3,
  output logic [6:0] matriz4,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B,
  output logic [2:0] vida,
  output logic       fim_jogo,
  output logic       vitoria
);

  estado_t                estado, proximo;
  resultado_t             res_c, res_r;
  logic [2:0]             col_l, lin_l, col_i, lin_i;
  logic                   valido;
  logic [NUM_LINHAS-1:0]  marcas  [NUM_COLUNAS];
  logic [NUM_LINHAS-1:0]  acertos [NUM_COLUNAS];
  logic [NUM_LINHAS-1:0]  mapa    [NUM_COLUNAS];
  logic [NUM_LINHAS-1:0]  novo_acerto;
  logic [2:0]             vida_r;
  logic                   derrota_c, vitoria_c, derrota_r, vitoria_r;
  logic                   ha_navio, sobra;
  logic                   carrega, tempo_fim;

  assign mapa[0] = mapa0;
  assign mapa[1] = mapa1;
  assign mapa[2] = mapa2;
  assign mapa[3] = mapa3;
  assign mapa[4] = mapa4;

  // Out-of-range coordinates are clamped so array indexing stays in bounds.
  assign valido = (col_l < 3'(NUM_COLUNAS)) && (lin_l < 3'(NUM_LINHAS));
  assign col_i  = valido ? col_l : 3'd0;
  assign lin_i  = valido ? lin_l : 3'd0;

  always_comb begin
    res_c = INVALIDO;
    if (valido) begin
      if (marcas[col_i][lin_i])    res_c = REPETIDO;
      else if (mapa[col_i][lin_i]) res_c = ACERTO;
      else                         res_c = ERRO;
    end
  end

  always_comb begin
    novo_acerto = (res_c == ACERTO) ? (NUM_LINHAS'(1) << lin_i) : '0;
    ha_navio    = 1'b0;
    sobra       = 1'b0;
    for (int c = 0; c < NUM_COLUNAS; c++) begin
      if (mapa[c] != '0) ha_navio = 1'b1;
      if ((mapa[c] & ~(acertos[c] | ((3'(c) == col_i) ? novo_acerto : '0))) != '0)
        sobra = 1'b1;
    end
    vitoria_c = ha_navio && !sobra;
    derrota_c = (res_c == ERRO) && (vida_r <= 3'd1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_l     <= '0;
      lin_l     <= '0;
      vida_r    <= 3'(VIDA_INICIAL);
      res_r     <= INVALIDO;
      derrota_r <= 1'b0;
      vitoria_r <= 1'b0;
      for (int c = 0; c < NUM_COLUNAS; c++) begin
        marcas[c]  <= '0;
        acertos[c] <= '0;
      end
    end else begin
      if (estado == OCIOSO && enable && confirmar) begin
        col_l <= coord_coluna;
        lin_l <= coord_linha;
      end
      if (estado == AVALIA) begin
        res_r     <= res_c;
        derrota_r <= derrota_c;
        vitoria_r <= vitoria_c;
        if (res_c == ACERTO || res_c == ERRO) marcas[col_i][lin_i] <= 1'b1;
        if (res_c == ACERTO) acertos[col_i][lin_i] <= 1'b1;
        if (res_c == ERRO && vida_r != 3'd0) vida_r <= vida_r - 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO: if (enable && confirmar) proximo = AVALIA;
      AVALIA: proximo = enable ? EXIBE : OCIOSO;
      EXIBE: begin
        if (!enable)        proximo = OCIOSO;
        else if (tempo_fim) proximo = (derrota_r || vitoria_r) ? FIM : OCIOSO;
      end
      FIM:     proximo = FIM;
      default: proximo = OCIOSO;
    endcase
  end

  always_comb begin
    carrega  = (estado == AVALIA);
    LED_R    = (estado == EXIBE && res_r == ERRO)   || (estado == FIM && derrota_r);
    LED_G    = (estado == EXIBE && res_r == ACERTO) || (estado == FIM && vitoria_r);
    LED_B    = (estado == EXIBE) && (res_r == INVALIDO || res_r == REPETIDO);
    fim_jogo = (estado == FIM);
    vitoria  = (estado == FIM) && vitoria_r;
  end

  contador_tempo #(.TEMPO_LED(TEMPO_LED)) u_contador (
    .clock (clock),
    .reset (reset),
    .load  (carrega),
    .done  (tempo_fim)
  );

  assign matriz0 = marcas[0];
  assign matriz1 = marcas[1];
  assign matriz2 = marcas[2];
  assign matriz3 = marcas[3];
  assign matriz4 = marcas[4];
  assign vida    = vida_r;

endmodule

// File: tb/tb_controlador_ataque.sv
// Self-checking bench: vector table, hand sequences and random shots against a cell-level model.
module tb_controlador_ataque;

  localparam int TEMPO = 4;
  localparam int VIDA0 = 5;

  logic       clock = 1'b0;
  logic       reset, enable, confirmar;
  logic [2:0] coord_coluna, coord_linha;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
  logic       LED_R, LED_G, LED_B;
  logic [2:0] vida;
  logic       fim_jogo, vitoria;

  controlador_ataque #(.VIDA_INICIAL(VIDA0), .TEMPO_LED(TEMPO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .confirmar(confirmar),
    .coord_coluna(coord_coluna), .coord_linha(coord_linha),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .matriz0(matriz0), .matriz1(matriz1), .matriz2(matriz2), .matriz3(matriz3), .matriz4(matriz4),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
    .vida(vida), .fim_jogo(fim_jogo), .vitoria(vitoria)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model: result codes 0 invalid, 1 repeated, 2 hit, 3 miss
  bit [6:0] m_marca [5];
  bit [6:0] m_acerto[5];
  bit [6:0] mp      [5];
  int       m_vida;
  bit       m_derrota, m_vitoria;

  typedef struct {
    int c;
    int r;
    int res;
    int vida;
    bit esp;
  } vetor_t;

  vetor_t tab[10];

  task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] dut_m();
    return {matriz4, matriz3, matriz2, matriz1, matriz0};
  endfunction

  function automatic logic [34:0] mod_m();
    return {m_marca[4], m_marca[3], m_marca[2], m_marca[1], m_marca[0]};
  endfunction

  function automatic logic [2:0] led_de(input int res);
    return {res == 3, res == 2, res <= 1};
  endfunction

  function automatic int modelo(input int c, input int r);
    int res;
    int navios;
    int faltam;
    if (c > 4 || r > 6)       res = 0;
    else if (m_marca[c][r])   res = 1;
    else if (mp[c][r]) begin
      res = 2;
      m_marca[c][r]  = 1'b1;
      m_acerto[c][r] = 1'b1;
    end else begin
      res = 3;
      m_marca[c][r] = 1'b1;
      if (m_vida > 0) m_vida--;
    end
    navios = 0;
    faltam = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 7; j++) begin
        if (mp[i][j]) navios++;
        if (mp[i][j] && !m_acerto[i][j]) faltam++;
      end
    m_derrota = (res == 3) && (m_vida == 0);
    m_vitoria = (navios > 0) && (faltam == 0);
    return res;
  endfunction

  task automatic set_mapa(input bit [6:0] a, b, c, d, e);
    mp[0] = a; mp[1] = b; mp[2] = c; mp[3] = d; mp[4] = e;
    mapa0 = a; mapa1 = b; mapa2 = c; mapa3 = d; mapa4 = e;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    confirmar = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_marca[i]  = '0;
      m_acerto[i] = '0;
    end
    m_vida    = VIDA0;
    m_derrota = 1'b0;
    m_vitoria = 1'b0;
  endtask

  task automatic check_reset_vals(input string nome);
    chk({nome, "_matriz"}, dut_m(), 35'd0);
    chk({nome, "_leds"}, {LED_R, LED_G, LED_B}, 3'b000);
    chk({nome, "_vida"}, vida, VIDA0);
    chk({nome, "_fim"}, {fim_jogo, vitoria}, 2'b00);
  endtask

  // One complete shot; res_tab/vida_tab >= 0 override the model's expectations.
  task automatic disparo(input int c, input int r, input bit esp, input int res_tab, input int vida_tab);
    int res;
    logic [2:0] exp_led;
    int exp_vida;
    bit fim_exp;
    res      = modelo(c, r);
    exp_led  = led_de(res_tab >= 0 ? res_tab : res);
    exp_vida = (vida_tab >= 0) ? vida_tab : m_vida;
    @(negedge clock);
    coord_coluna = 3'(c);
    coord_linha  = 3'(r);
    confirmar    = 1'b1;
    @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
    chk("led_resultado", {LED_R, LED_G, LED_B}, exp_led);
    chk("vida", vida, exp_vida);
    chk("matriz", dut_m(), mod_m());
    for (int k = 1; k < TEMPO; k++) begin
      if (esp && k == 1) begin
        confirmar    = 1'b1;
        coord_coluna = 3'($urandom_range(0, 4));
        coord_linha  = 3'($urandom_range(0, 6));
      end
      @(negedge clock);
      confirmar = 1'b0;
      chk("led_hold", {LED_R, LED_G, LED_B}, exp_led);
    end
    @(negedge clock);
    fim_exp = m_derrota || m_vitoria;
    chk("fim_jogo", fim_jogo, fim_exp);
    chk("vitoria", vitoria, m_vitoria);
    chk("led_pos", {LED_R, LED_G, LED_B}, fim_exp ? {m_derrota, m_vitoria, 1'b0} : 3'b000);
    if (esp) chk("matriz_ignora", dut_m(), mod_m());
  endtask

  task automatic fim_estavel(input string nome);
    logic [2:0] led_exp;
    led_exp = {m_derrota, m_vitoria, 1'b0};
    @(negedge clock);
    coord_coluna = 3'd4;
    coord_linha  = 3'd6;
    confirmar    = 1'b1;
    @(negedge clock);
    confirmar = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk({nome, "_led"}, {LED_R, LED_G, LED_B}, led_exp);
      chk({nome, "_fim"}, {fim_jogo, vitoria}, {1'b1, m_vitoria});
    end
    chk({nome, "_matriz"}, dut_m(), mod_m());
    chk({nome, "_vida"}, vida, m_vida);
  endtask

  initial begin
    int res;
    reset = 1'b1; enable = 1'b1; confirmar = 1'b0;
    coord_coluna = '0; coord_linha = '0;
    set_mapa(7'b0000000, 7'b0000000, 7'b0000100, 7'b0000000, 7'b1000000);

    tab[0] = '{2, 2, 2, 5, 1'b1};
    tab[1] = '{0, 0, 3, 4, 1'b0};
    tab[2] = '{0, 0, 1, 4, 1'b0};
    tab[3] = '{6, 1, 0, 4, 1'b0};
    tab[4] = '{2, 2, 1, 4, 1'b0};
    tab[5] = '{1, 5, 3, 3, 1'b1};
    tab[6] = '{4, 7, 0, 3, 1'b0};
    tab[7] = '{7, 7, 0, 3, 1'b0};
    tab[8] = '{4, 0, 3, 2, 1'b0};
    tab[9] = '{3, 6, 3, 1, 1'b0};

    do_reset();
    check_reset_vals("reset_inicial");

    for (int i = 0; i < 10; i++)
      disparo(tab[i].c, tab[i].r, tab[i].esp, tab[i].res, tab[i].vida);

    // five misses -> defeat
    do_reset();
    for (int i = 0; i < 5; i++) disparo(0, i, 1'b0, 3, 4 - i);
    fim_estavel("derrota");

    // three-cell fleet -> victory
    do_reset();
    set_mapa(7'b0000001, 7'b0100000, 7'b0000000, 7'b0001000, 7'b0000000);
    disparo(0, 0, 1'b0, 2, 5);
    disparo(2, 0, 1'b0, 3, 4);
    disparo(1, 5, 1'b0, 2, 4);
    disparo(3, 3, 1'b1, 2, 4);
    fim_estavel("vitoria");

    // reset together with confirmar
    set_mapa(7'b0000000, 7'b0000000, 7'b0000100, 7'b0000000, 7'b1000000);
    @(negedge clock);
    reset = 1'b1; confirmar = 1'b1; coord_coluna = 3'd0; coord_linha = 3'd0;
    @(negedge clock);
    reset = 1'b0; confirmar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_vals("reset_confirmar");

    // reset in the middle of EXIBE
    do_reset();
    @(negedge clock);
    coord_coluna = 3'd2; coord_linha = 3'd2; confirmar = 1'b1;
    @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
    chk("exibe_antes_reset", {LED_R, LED_G, LED_B}, 3'b010);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("reset_exibe");
    reset = 1'b0;

    // enable falls in EXIBE
    do_reset();
    res = modelo(0, 0);
    @(negedge clock);
    coord_coluna = 3'd0; coord_linha = 3'd0; confirmar = 1'b1;
    @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
    chk("en_exibe_led", {LED_R, LED_G, LED_B}, led_de(res));
    enable = 1'b0;
    @(negedge clock);
    chk("en_exibe_apaga", {LED_R, LED_G, LED_B}, 3'b000);
    chk("en_exibe_matriz", dut_m(), mod_m());
    chk("en_exibe_vida", vida, m_vida);
    enable = 1'b1;
    disparo(2, 2, 1'b0, -1, -1);

    // enable falls in AVALIA
    res = modelo(1, 1);
    @(negedge clock);
    coord_coluna = 3'd1; coord_linha = 3'd1; confirmar = 1'b1;
    @(negedge clock);
    confirmar = 1'b0; enable = 1'b0;
    @(negedge clock);
    chk("en_avalia_led", {LED_R, LED_G, LED_B}, 3'b000);
    chk("en_avalia_matriz", dut_m(), mod_m());
    chk("en_avalia_vida", vida, m_vida);
    confirmar = 1'b1; coord_coluna = 3'd3; coord_linha = 3'd3;
    @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("sem_enable_matriz", dut_m(), mod_m());
    enable = 1'b1;
    disparo(3, 3, 1'b0, -1, -1);

    // random games against the model
    for (int rodada = 0; rodada < 15; rodada++) begin
      bit [6:0] m[5];
      do_reset();
      for (int i = 0; i < 5; i++)
        m[i] = 7'($urandom_range(0, 127) & $urandom_range(0, 127) & $urandom_range(0, 127));
      if ((m[0] | m[1] | m[2] | m[3] | m[4]) == 7'd0) m[2] = 7'b0001000;
      set_mapa(m[0], m[1], m[2], m[3], m[4]);
      for (int s = 0; s < 45; s++) begin
        int c;
        int r;
        if ($urandom_range(0, 9) == 0) begin
          c = $urandom_range(0, 7);
          r = $urandom_range(7, 7);
        end else begin
          c = $urandom_range(0, 4);
          r = $urandom_range(0, 6);
          if ($urandom_range(0, 1) == 1)
            for (int t = 0; t < 20 && !mp[c][r]; t++) begin
              c = $urandom_range(0, 4);
              r = $urandom_range(0, 6);
            end
        end
        disparo(c, r, ($urandom_range(0, 3) == 0), -1, -1);
        if (m_derrota || m_vitoria) break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
